spart_driver: RTL
=================

Name: spart_driver

Overview:
- Processor-side sequencer for the SPART transceiver.
- After reset it programs the SPART baud divisor from the board switches (br_cfg).
- It then runs an echo loop: wait for a received byte (rda), read it, wait for the transmit buffer (tbr), write the byte back.
- Sits between the board I/O (SW, KEY) and the SPART bus interface inside the lab top level.

Parameters:
- SYNC_STAGES, 2, flops in the br_cfg synchronizer (switch input is asynchronous).

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- br_cfg  in  2  baud select from switches (asynchronous)
- rda  in  1  SPART receive-data-available
- tbr  in  1  SPART transmit-buffer-ready
- data_in  in  8  SPART read data; valid in a cycle with iocs=1, iorw=1
- iocs  out  1  bus chip select, one-cycle pulse per access
- iorw  out  1  1 = read, 0 = write
- ioaddr  out  2  00 tx/rx buffer, 01 status (unused), 10 divisor low, 11 divisor high
- data_out  out  8  write data; valid when iocs=1, iorw=0
- cfg_done  out  1  high while a divisor is programmed and the echo loop is live
- rx_count  out  8  bytes echoed, wraps 255 -> 0

Behaviour:
- Reset (rst_n=0 at posedge):
  - Outputs: iocs=0, iorw=1, ioaddr=00, data_out=0x00, cfg_done=0, rx_count=0.
  - FSM goes to CFG_LO; held byte discarded; synchronizer flops cleared to 00.
- Divisor table (package constants): cfg 00 -> 651, 01 -> 326, 10 -> 163, 11 -> 81 (clocks per bit, 16-bit).
- States:
  - CFG_LO:
    - Latch sync br_cfg into cfg_cur.
    - Drive iocs=1, iorw=0, ioaddr=10, data_out = divisor[7:0]; -> CFG_HI.
  - CFG_HI: iocs=1, iorw=0, ioaddr=11, data_out = divisor[15:8]; set cfg_done next cycle; -> WAIT_RDA.
  - WAIT_RDA:
    - iocs=0.
    - If sync br_cfg != cfg_cur: clear cfg_done, -> CFG_LO.
    - Else if rda: -> READ.
  - READ: iocs=1, iorw=1, ioaddr=00; capture data_in at this edge into hold register; -> WAIT_TBR.
  - WAIT_TBR: iocs=0; when tbr -> WRITE. br_cfg changes are ignored here.
  - WRITE: iocs=1, iorw=0, ioaddr=00, data_out = hold; rx_count += 1 (8-bit wrap); -> WAIT_RDA.
- Latency and access rules:
  - Each access is exactly one cycle of iocs. The SPART must drop rda/tbr by the cycle after the access.
  - rda seen high in WAIT_RDA -> iocs read pulse on the next cycle.
  - tbr seen high in WAIT_TBR -> iocs write pulse on the next cycle.
- Boundaries:
  - br_cfg change with a byte held: echo completes first, then reprogram; the byte is never lost or duplicated.
  - rda and a br_cfg change in the same WAIT_RDA cycle: reprogram wins; the byte stays pending in the SPART.
  - tbr already high on entry to WAIT_TBR: write issues the next cycle; no extra wait.
  - rst_n low mid-access: iocs drops at that edge; no partial second divisor byte is written.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SPART_DRV_UPCASE_EN.
- Defined: in WRITE, hold bytes 0x61-0x7A ('a'-'z') go out minus 0x20; all other bytes unchanged.
- Undefined: bytes echo verbatim.
- rx_count behaves the same either way.

Decomposition:
- Package spart_pkg holds:
  - ioaddr enum (ADDR_BUF, ADDR_STAT, ADDR_DBL, ADDR_DBH);
  - the FSM state enum;
  - the 4-entry divisor constant array, 16-bit.
- One sub-module: spart_cfg_sync.
  - SYNC_STAGES-deep synchronizer on br_cfg.
  - Outputs the synchronized value plus a change flag versus cfg_cur.

Test Plan:
- Reset then br_cfg=00 -> write pulses: ioaddr=10 data 0x8B, next cycle ioaddr=11 data 0x02; cfg_done=1 the following cycle.
- rda pulse with data_in=0x55, tbr=1 -> read pulse (ioaddr=00, iorw=1) next cycle; write pulse with data_out=0x55 two cycles later; rx_count=1.
- Hold tbr=0 for 500 cycles after a read of 0xA3 -> iocs stays 0; tbr=1 -> single write of 0xA3.
- br_cfg 00 -> 11 while in WAIT_TBR holding 0x31 -> 0x31 echoed first, then divisor 0x0051/0x00 written; cfg_done low only during reprogram.
- 256 echoes -> rx_count returns to 0x00. With SPART_DRV_UPCASE_EN: 0x61 -> 0x41, 0x7B -> 0x7B.
- rst_n=0 on the CFG_HI cycle -> iocs=0 next edge; after release the full CFG_LO/CFG_HI sequence repeats.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART processor-side driver.
// Holds the bus address enum, FSM states and baud divisor table.
package spart_pkg;

  typedef enum logic [1:0] {
    ADDR_BUF  = 2'b00,
    ADDR_STAT = 2'b01,
    ADDR_DBL  = 2'b10,
    ADDR_DBH  = 2'b11
  } ioaddr_e;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    WAIT_RDA,
    READ,
    WAIT_TBR,
    WRITE
  } state_e;

  // Clocks per bit, indexed by br_cfg (entry 0 is rightmost).
  localparam logic [3:0][15:0] DIVISOR = {
    16'd81,
    16'd163,
    16'd326,
    16'd651
  };

  // ASCII 'a'..'z' folded to upper case; all else passes through.
  function automatic logic [7:0] upcase(
    input logic [7:0] b
  );
    if (b >= 8'h61 && b <= 8'h7A) begin
      return b - 8'h20;
    end
    return b;
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// SPART bus between the driver (master) and the transceiver (slave).
// master: drives iocs/iorw/ioaddr/data_out, reads rda/tbr/data_in.
interface spart_driver_if;

  logic       rda;
  logic       tbr;
  logic [7:0] data_in;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] data_out;

  modport master (
    input  rda,
    input  tbr,
    input  data_in,
    output iocs,
    output iorw,
    output ioaddr,
    output data_out
  );

  modport slave (
    output rda,
    output tbr,
    output data_in,
    input  iocs,
    input  iorw,
    input  ioaddr,
    input  data_out
  );

endinterface

// File: rtl/spart_cfg_sync.sv
// Multi-flop synchronizer for the asynchronous br_cfg switches.
// Ports: clk, rst_n, br_cfg_i (async), cfg_cur_i (latched config),
// cfg_sync_o (synchronized value), chg_o (sync value != cfg_cur_i).
module spart_cfg_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg_i,
  input  logic [1:0] cfg_cur_i,
  output logic [1:0] cfg_sync_o,
  output logic       chg_o
);

  logic [SYNC_STAGES-1:0][1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= br_cfg_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign cfg_sync_o = sync_q[SYNC_STAGES-1];
  assign chg_o      = (sync_q[SYNC_STAGES-1] != cfg_cur_i);

endmodule

// File: rtl/spart_driver.sv
// Processor-side SPART sequencer: programs the baud divisor from
// br_cfg after reset, then echoes every received byte back.
// Ports: clk, rst_n (sync, active low), br_cfg (async switches),
// bus (spart_driver_if.master: rda/tbr/data_in in,
// iocs/iorw/ioaddr/data_out out), cfg_done, rx_count.
// Optional: define SPART_DRV_UPCASE_EN to upper-case echoed a..z.
module spart_driver
  import spart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           br_cfg,
  spart_driver_if.master       bus,
  output logic                 cfg_done,
  output logic [7:0]           rx_count
);

  state_e     state_q, state_d;
  logic [1:0] cfg_cur_q, cfg_cur_d;
  logic [7:0] hold_q, hold_d;
  logic       iocs_q, iocs_d;
  logic       iorw_q, iorw_d;
  ioaddr_e    ioaddr_q, ioaddr_d;
  logic [7:0] dout_q, dout_d;
  logic       done_q, done_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0] cfg_sync;
  logic       cfg_chg;

  spart_cfg_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .br_cfg_i   (br_cfg),
    .cfg_cur_i  (cfg_cur_q),
    .cfg_sync_o (cfg_sync),
    .chg_o      (cfg_chg)
  );

  // Outputs are registered. Divisor bytes go out on the edge that
  // leaves CFG_LO/CFG_HI, so reset can park in CFG_LO with the bus
  // idle. Read/write pulses are raised on the edge entering
  // READ/WRITE, so iocs is high exactly while in those states.
  always_comb begin
    state_d   = state_q;
    cfg_cur_d = cfg_cur_q;
    hold_d    = hold_q;
    iocs_d    = 1'b0;
    iorw_d    = 1'b1;
    ioaddr_d  = ADDR_BUF;
    dout_d    = dout_q;
    done_d    = done_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      CFG_LO: begin
        cfg_cur_d = cfg_sync;
        iocs_d    = 1'b1;
        iorw_d    = 1'b0;
        ioaddr_d  = ADDR_DBL;
        dout_d    = DIVISOR[cfg_sync][7:0];
        state_d   = CFG_HI;
      end
      CFG_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = ADDR_DBH;
        dout_d   = DIVISOR[cfg_cur_q][15:8];
        state_d  = WAIT_RDA;
      end
      WAIT_RDA: begin
        // A switch change beats a pending byte; the
        // byte stays in the SPART until we come back.
        if (cfg_chg) begin
          done_d  = 1'b0;
          state_d = CFG_LO;
        end else begin
          done_d = 1'b1;
          if (bus.rda) begin
            iocs_d   = 1'b1;
            iorw_d   = 1'b1;
            ioaddr_d = ADDR_BUF;
            state_d  = READ;
          end
        end
      end
      READ: begin
        hold_d  = bus.data_in;
        state_d = WAIT_TBR;
      end
      WAIT_TBR: begin
        if (bus.tbr) begin
          iocs_d   = 1'b1;
          iorw_d   = 1'b0;
          ioaddr_d = ADDR_BUF;
`ifdef SPART_DRV_UPCASE_EN
          dout_d   = upcase(hold_q);
`else
          dout_d   = hold_q;
`endif
          cnt_d    = cnt_q + 8'd1;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        state_d = WAIT_RDA;
      end
      default: begin
        state_d = CFG_LO;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CFG_LO;
      cfg_cur_q <= 2'b00;
      hold_q    <= 8'h00;
      iocs_q    <= 1'b0;
      iorw_q    <= 1'b1;
      ioaddr_q  <= ADDR_BUF;
      dout_q    <= 8'h00;
      done_q    <= 1'b0;
      cnt_q     <= 8'h00;
    end else begin
      state_q   <= state_d;
      cfg_cur_q <= cfg_cur_d;
      hold_q    <= hold_d;
      iocs_q    <= iocs_d;
      iorw_q    <= iorw_d;
      ioaddr_q  <= ioaddr_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.iocs     = iocs_q;
  assign bus.iorw     = iorw_q;
  assign bus.ioaddr   = ioaddr_q;
  assign bus.data_out = dout_q;
  assign cfg_done     = done_q;
  assign rx_count     = cnt_q;

endmodule
